mul_norm_round_pipe: RTL and testbench

- Two-stage pipelined normalise-and-round stage of the FPU_MUL datapath.
- Sits directly downstream of the 24x24 mantissa multiplier.
- Takes the 48-bit product, biased exponent sum and sign, and produces an IEEE-754 single-precision result.
- Uses the 24-bit leading-one detector for left-shift normalisation, rounds to nearest even, and applies overflow and underflow saturation.
- Has a valid/ready handshake on both sides.

---
 rtl/fpu_mul_pkg.sv | 29 ++
 rtl/mul_norm_round_pipe_lopd.sv | 21 ++
 rtl/mul_norm_round_pipe.sv | 137 +++++++++++++
 tb/tb_mul_norm_round_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_mul_pkg.sv
// Shared types and constants for the FPU_MUL datapath.
package fpu_mul_pkg;

    localparam int MANT_W = 48;
    localparam int EXP_W  = 10;
    localparam int LOPD_W = 5;

    localparam int          EXP_BIAS = 127;
    localparam int          EXP_MAX  = 255;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        FP_NORMAL = 2'b00,
        FP_ZERO   = 2'b01,
        FP_INF    = 2'b10,
        FP_NAN    = 2'b11
    } fp_special_e;

    // Everything stage 2 needs to finish normalising and rounding one beat
    typedef struct packed {
        logic                     sign;
        logic signed [EXP_W-1:0]  exp;
        fp_special_e              special;
        logic [MANT_W-1:0]        mant;
        logic [LOPD_W-1:0]        lz;
        logic                     zf;
    } stage1_t;

endpackage

// File: rtl/mul_norm_round_pipe_lopd.sv
// 24-bit leading-one detector: reports the leading-zero count and an all-zero flag.
module MUL_LOPD_24bit
    import fpu_mul_pkg::*;
(
    input  logic [23:0]       i_data,
    output logic [LOPD_W-1:0] o_lz,
    output logic              o_zf
);

    // Scan upwards so the highest set bit writes last and wins
    always_comb begin
        o_lz = '0;
        o_zf = (i_data == 24'h0);
        for (int i = 0; i < 24; i++) begin
            if (i_data[i]) begin
                o_lz = LOPD_W'(23 - i);
            end
        end
    end

endmodule

// File: rtl/mul_norm_round_pipe.sv
// Two-stage normalise and round-to-nearest-even stage behind the 24x24 mantissa multiplier.
module mul_norm_round_pipe
    import fpu_mul_pkg::*;
#(
    parameter int SIZE_MANT = MANT_W,
    parameter int SIZE_EXP  = EXP_W,
    parameter int SIZE_LOPD = LOPD_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_sign,
    input  logic [SIZE_EXP-1:0]  i_exp,
    input  logic [SIZE_MANT-1:0] i_mant,
    input  logic [1:0]           i_special,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [31:0]          o_result,
    output logic                 o_overflow,
    output logic                 o_underflow
);

    localparam int EW2 = SIZE_EXP + 2;
    localparam logic signed [EW2-1:0] EXP_SAT  = EW2'(EXP_MAX);
    localparam logic signed [EW2-1:0] EXP_ZERO = '0;

    logic                 v1_q;
    logic                 v2_q;
    logic                 en_1;
    logic                 en_2;
    stage1_t              s1_d;
    stage1_t              s1_q;
    logic [SIZE_LOPD-1:0] lopd_lz;
    logic                 lopd_zf;

    logic [SIZE_MANT-1:0] shifted;
    logic [22:0]          mant_m;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic [23:0]          mant_sum;
    logic [22:0]          mant_final;
    logic signed [EW2-1:0] exp_norm;
    logic signed [EW2-1:0] exp_final;
    logic [31:0]          result_d;
    logic                 ovf_d;
    logic                 unf_d;

    // A stage may load when it is empty or its contents move on this cycle
    assign en_2    = ~v2_q | i_ready;
    assign en_1    = ~v1_q | en_2;
    assign o_ready = en_1;
    assign o_valid = v2_q;

    MUL_LOPD_24bit u_lopd (
        .i_data (i_mant[SIZE_MANT-1 -: 24]),
        .o_lz   (lopd_lz),
        .o_zf   (lopd_zf)
    );

    // Gather the incoming beat together with its leading-zero count
    always_comb begin
        s1_d         = '0;
        s1_d.sign    = i_sign;
        s1_d.exp     = i_exp;
        s1_d.special = fp_special_e'(i_special);
        s1_d.mant    = i_mant;
        s1_d.lz      = lopd_lz;
        s1_d.zf      = lopd_zf;
    end

    // Stage 1 register: hold while stalled, capture only real beats
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1_q <= 1'b0;
            s1_q <= '0;
        end else if (en_1) begin
            v1_q <= i_valid;
            if (i_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // Normalise, round to nearest even, then pick the result by priority
    always_comb begin
        shifted    = s1_q.mant << s1_q.lz;
        mant_m     = shifted[SIZE_MANT-2 -: 23];
        guard      = shifted[SIZE_MANT-25];
        sticky     = |shifted[SIZE_MANT-26:0];
        round_up   = guard & (sticky | mant_m[0]);
        mant_sum   = {1'b0, mant_m} + {23'b0, round_up};
        exp_norm   = EW2'($signed(s1_q.exp)) + EW2'(1) - EW2'(s1_q.lz);
        exp_final  = exp_norm;
        mant_final = mant_sum[22:0];
        if (mant_sum[23]) begin
            exp_final  = exp_norm + EW2'(1);
            mant_final = 23'h0;
        end

        result_d = {s1_q.sign, exp_final[7:0], mant_final};
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        if (s1_q.special == FP_NAN) begin
            result_d = QNAN;
        end else if (s1_q.special == FP_INF) begin
            result_d = {s1_q.sign, 8'hFF, 23'h0};
        end else if (s1_q.special == FP_ZERO || s1_q.zf) begin
            result_d = {s1_q.sign, 31'h0};
        end else if (exp_final >= EXP_SAT) begin
            result_d = {s1_q.sign, 8'hFF, 23'h0};
            ovf_d    = 1'b1;
        end else if (exp_final <= EXP_ZERO) begin
            result_d = {s1_q.sign, 31'h0};
            unf_d    = 1'b1;
        end
    end

    // Stage 2 register drives the outputs; result stays frozen while stalled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v2_q        <= 1'b0;
            o_result    <= 32'h0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else if (en_2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                o_result    <= result_d;
                o_overflow  <= ovf_d;
                o_underflow <= unf_d;
            end
        end
    end

endmodule

// File: tb/tb_mul_norm_round_pipe.sv
// Self-checking bench for mul_norm_round_pipe: directed cases plus randomized streaming against a value-level model.
module tb_mul_norm_round_pipe;

    logic               i_clk;
    logic               i_rst_n;
    logic               i_valid;
    logic               o_ready;
    logic               i_sign;
    logic signed [9:0]  i_exp;
    logic [47:0]        i_mant;
    logic [1:0]         i_special;
    logic               o_valid;
    logic               i_ready;
    logic [31:0]        o_result;
    logic               o_overflow;
    logic               o_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [33:0] sb[$];
    bit          hold;
    bit          stall_prev;
    logic [33:0] held_out;
    int          n_pushed;

    logic               cur_sign;
    logic signed [9:0]  cur_exp;
    logic [1:0]         cur_special;
    logic [47:0]        cur_mant;

    mul_norm_round_pipe dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_sign      (i_sign),
        .i_exp       (i_exp),
        .i_mant      (i_mant),
        .i_special   (i_special),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference: value = P * 2^(exp-127-46); round the top 24 significant bits to nearest even
    function automatic logic [33:0] ref_model(input logic sign, input logic signed [9:0] exp_in,
                                              input logic [1:0] sp, input logic [47:0] p);
        int msb;
        int sh;
        int e;
        longint unsigned sig;
        longint unsigned rem;
        longint unsigned half;
        msb = -1;
        for (int i = 24; i < 48; i++) begin
            if (p[i]) msb = i;
        end
        if (sp == 2'b11) return {2'b00, 32'h7FC0_0000};
        if (sp == 2'b10) return {2'b00, sign, 8'hFF, 23'h0};
        if (sp == 2'b01 || msb < 0) return {2'b00, sign, 31'h0};
        sh   = msb - 23;
        sig  = 64'(p) >> sh;
        rem  = 64'(p) & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && sig[0])) sig = sig + 64'd1;
        e = int'(exp_in) + msb - 46;
        if (sig == (64'd1 << 24)) begin
            sig = sig >> 1;
            e   = e + 1;
        end
        if (e >= 255) return {2'b10, sign, 8'hFF, 23'h0};
        if (e <= 0)   return {2'b01, sign, 31'h0};
        return {2'b00, sign, e[7:0], sig[22:0]};
    endfunction

    task automatic check_output(input string tag, input logic [33:0] obs, input logic [33:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic random_beat();
        int k;
        logic [63:0] r;
        cur_sign = 1'($urandom_range(0, 1));
        cur_exp  = 10'(int'($urandom_range(0, 340)) - 40);
        k = int'($urandom_range(0, 15));
        cur_special = (k == 0) ? 2'b11 : (k == 1) ? 2'b10 : (k == 2) ? 2'b01 : 2'b00;
        r = {$urandom, $urandom};
        cur_mant = r[47:0];
        k = int'($urandom_range(0, 9));
        if (k <= 3) begin
            cur_mant[47] = 1'b1;
        end else if (k <= 6) begin
            cur_mant[47:46] = 2'b01;
        end else if (k == 7) begin
            cur_mant = cur_mant >> $urandom_range(2, 23);
        end else if (k == 8) begin
            cur_mant[47]   = 1'b1;
            cur_mant[23:0] = {1'b1, 23'h0};
        end else begin
            cur_mant = cur_mant >> $urandom_range(24, 47);
        end
    endtask

    // One clock of streaming: drive at negedge, check handshake and outputs 1 ns later
    task automatic apply_stimulus(input bit want_valid, input bit rdy);
        @(negedge i_clk);
        if (!hold) random_beat();
        i_valid   = want_valid;
        i_ready   = rdy;
        i_sign    = cur_sign;
        i_exp     = cur_exp;
        i_special = cur_special;
        i_mant    = cur_mant;
        #1;
        check_output("o_ready", {33'b0, o_ready}, {33'b0, (sb.size() < 2) || rdy});
        if (stall_prev) begin
            check_output("stall_valid", {33'b0, o_valid}, 34'd1);
            check_output("stall_hold", {o_overflow, o_underflow, o_result}, held_out);
        end
        if (o_valid && rdy) begin
            check_output("sb_has_entry", {33'b0, sb.size() != 0}, 34'd1);
            if (sb.size() != 0) begin
                check_output("stream_result", {o_overflow, o_underflow, o_result}, sb.pop_front());
            end
        end
        stall_prev = o_valid && !rdy;
        held_out   = {o_overflow, o_underflow, o_result};
        if (want_valid && o_ready) begin
            sb.push_back(ref_model(cur_sign, cur_exp, cur_special, cur_mant));
            n_pushed++;
        end
        hold = want_valid && !o_ready;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < 20) begin
            apply_stimulus(1'b0, 1'b1);
            cyc++;
        end
        apply_stimulus(1'b0, 1'b1);
        check_output("drained", 34'(sb.size()), 34'd0);
    endtask

    // Single beat on an empty pipe: accepted, invisible after 1 cycle, valid with result after 2
    task automatic run_directed(input string tag, input logic s, input logic signed [9:0] e,
                                input logic [1:0] sp, input logic [47:0] p, input logic [33:0] exp_v);
        stall_prev = 1'b0;
        hold       = 1'b0;
        @(negedge i_clk);
        i_valid = 1'b1; i_ready = 1'b1;
        i_sign = s; i_exp = e; i_special = sp; i_mant = p;
        #1;
        check_output({tag, "/ready"}, {33'b0, o_ready}, 34'd1);
        @(negedge i_clk);
        i_valid = 1'b0;
        #1;
        check_output({tag, "/lat1"}, {33'b0, o_valid}, 34'd0);
        @(negedge i_clk);
        #1;
        check_output({tag, "/lat2"}, {33'b0, o_valid}, 34'd1);
        check_output(tag, {o_overflow, o_underflow, o_result}, exp_v);
    endtask

    initial begin
        hold = 1'b0; stall_prev = 1'b0; held_out = '0; n_pushed = 0;
        i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_sign = 1'b0; i_exp = '0; i_special = 2'b00; i_mant = '0;
        cur_sign = 1'b0; cur_exp = '0; cur_special = 2'b00; cur_mant = '0;
        #12;
        check_output("reset_outputs", {o_overflow, o_underflow, o_result}, 34'h0);
        check_output("reset_valid", {33'b0, o_valid}, 34'd0);
        check_output("reset_ready", {33'b0, o_ready}, 34'd1);
        i_rst_n = 1'b1;

        run_directed("mul_1p5x1p5", 1'b0, 10'sd127, 2'b00, 48'h9000_0000_0000, {2'b00, 32'h4010_0000});
        run_directed("mul_1x1",     1'b0, 10'sd127, 2'b00, 48'h4000_0000_0000, {2'b00, 32'h3F80_0000});
        run_directed("tie_even",    1'b0, 10'sd127, 2'b00, 48'h4000_0040_0000, {2'b00, 32'h3F80_0000});
        run_directed("tie_odd",     1'b0, 10'sd127, 2'b00, 48'h4000_00C0_0000, {2'b00, 32'h3F80_0002});
        run_directed("round_carry", 1'b0, 10'sd127, 2'b00, 48'hFFFF_FF80_0000, {2'b00, 32'h4080_0000});
        run_directed("overflow",    1'b1, 10'sd254, 2'b00, 48'h9000_0000_0000, {2'b10, 32'hFF80_0000});
        run_directed("carry_ovf",   1'b0, 10'sd253, 2'b00, 48'hFFFF_FF80_0000, {2'b10, 32'h7F80_0000});
        run_directed("underflow",   1'b0, -10'sd1,  2'b00, 48'h4000_0000_0000, {2'b01, 32'h0000_0000});
        run_directed("exp_zero",    1'b0, 10'sd0,   2'b00, 48'h4000_0000_0000, {2'b01, 32'h0000_0000});
        run_directed("exp_one",     1'b0, 10'sd0,   2'b00, 48'h9000_0000_0000, {2'b00, 32'h0090_0000});
        run_directed("special_nan", 1'b1, 10'sd127, 2'b11, 48'h9000_0000_0000, {2'b00, 32'h7FC0_0000});
        run_directed("special_inf", 1'b1, 10'sd127, 2'b10, 48'h9000_0000_0000, {2'b00, 32'hFF80_0000});
        run_directed("special_zero",1'b1, 10'sd127, 2'b01, 48'h9000_0000_0000, {2'b00, 32'h8000_0000});
        run_directed("lopd_zero",   1'b0, 10'sd127, 2'b00, 48'h0000_00FF_FFFF, {2'b00, 32'h0000_0000});
        hold = 1'b0; stall_prev = 1'b0;
        apply_stimulus(1'b0, 1'b1);

        // Four beats with i_ready dropped for three cycles in the middle
        n_pushed = 0;
        for (int cyc = 0; cyc < 20 && n_pushed < 4; cyc++) begin
            apply_stimulus(1'b1, (cyc < 2 || cyc > 4));
        end
        check_output("bp_beats_sent", 34'(n_pushed), 34'd4);
        drain();

        // Randomized streaming with random valid and ready
        for (int cyc = 0; cyc < 400; cyc++) begin
            apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
        end
        drain();

        // Reset with beats in flight: outputs clear at once and nothing emerges afterwards
        for (int cyc = 0; cyc < 3; cyc++) apply_stimulus(1'b1, 1'b1);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        #1;
        check_output("midrst_valid", {33'b0, o_valid}, 34'd0);
        check_output("midrst_outputs", {o_overflow, o_underflow, o_result}, 34'h0);
        sb.delete();
        hold = 1'b0; stall_prev = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            apply_stimulus(1'b0, 1'b1);
            check_output("post_rst_idle", {33'b0, o_valid}, 34'd0);
        end
        run_directed("post_rst_beat", 1'b0, 10'sd127, 2'b00, 48'h9000_0000_0000, {2'b00, 32'h4010_0000});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
